// File: rtl/seqdet_pkg.sv
// Shared limits and default pattern for the serial one-hot sequence detector.
package seqdet_pkg;

  localparam int unsigned PAT_LEN_MAX = 16;
  localparam int unsigned CNT_W_MAX   = 16;
  localparam logic [3:0]  PAT_DEFAULT = 4'b1011;

endpackage

// File: rtl/seqdet_prefix_match.sv
// Next-state logic: longest suffix of the accepted stream that is a prefix of the pattern.
// In S_N the stream restarts unless overlap is set.
module seqdet_prefix_match #(
  parameter int unsigned PAT_LEN = 4
) (
  input  logic [PAT_LEN-1:0] history,
  input  logic               in,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic [PAT_LEN:0]   state,
  input  logic               overlap,
  output logic [PAT_LEN:0]   next_state_c
);

  logic [PAT_LEN-1:0] window;
  logic [PAT_LEN:1]   suffix_hit;
  logic [PAT_LEN:1]   allowed;
  logic               found;
  logic               unused_hist_msb;

  // Newest bit at [0]; a full-length match needs only PAT_LEN-1 older bits.
  assign window          = {history[PAT_LEN-2:0], in};
  assign unused_hist_msb = history[PAT_LEN-1];

  always_comb begin
    suffix_hit   = '0;
    allowed      = '0;
    next_state_c = '0;
    found        = 1'b0;

    // k may only reach c+1 from S_c; from S_N it is N (overlap) or 1 (restart).
    for (int k = 1; k <= int'(PAT_LEN); k++) begin
      suffix_hit[k] = 1'b1;
      for (int j = 0; j < k; j++) begin
        if (window[j] != pattern[int'(PAT_LEN) - k + j]) suffix_hit[k] = 1'b0;
      end
      allowed[k] = (state[PAT_LEN] && (overlap || (k == 1))) ||
                   (|(state[PAT_LEN-1:0] >> (k - 1)));
    end

    for (int k = int'(PAT_LEN); k >= 1; k--) begin
      if (!found && suffix_hit[k] && allowed[k]) begin
        next_state_c[k] = 1'b1;
        found           = 1'b1;
      end
    end
    if (!found) next_state_c[0] = 1'b1;
  end

endmodule

// File: rtl/onehot_seq_detector.sv
// Serial pattern detector with one-hot state, loadable pattern and overlap control.
// Match counter is built only when ONEHOT_SEQ_DETECTOR_CNT_EN is defined.
module onehot_seq_detector
  import seqdet_pkg::*;
#(
  parameter int unsigned        PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PAT_RST = PAT_LEN'(PAT_DEFAULT),
  parameter int unsigned        CNT_W   = 8
) (
  input  logic               clk,
  input  logic               aresetn,
  input  logic               in_valid,
  input  logic               in,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               overlap,
  input  logic               cnt_clr,
  output logic [PAT_LEN:0]   state,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam logic [PAT_LEN:0] S_IDLE = {{PAT_LEN{1'b0}}, 1'b1};

  logic [PAT_LEN:0]   state_q;
  logic [PAT_LEN:0]   state_nxt_c;
  logic [PAT_LEN-1:0] pattern_q;
  logic [PAT_LEN-1:0] history_q;

  seqdet_prefix_match #(
    .PAT_LEN (PAT_LEN)
  ) u_prefix_match (
    .history      (history_q),
    .in           (in),
    .pattern      (pattern_q),
    .state        (state_q),
    .overlap      (overlap),
    .next_state_c (state_nxt_c)
  );

  // State register; a pattern load wins over an accepted bit.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
    end else if (pat_load) begin
      state_q <= S_IDLE;
    end else if (in_valid) begin
      state_q <= state_nxt_c;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      pattern_q <= PAT_RST;
      history_q <= '0;
    end else if (pat_load) begin
      pattern_q <= pat_in;
      history_q <= '0;
    end else if (in_valid) begin
      history_q <= {history_q[PAT_LEN-2:0], in};
    end
  end

  always_comb begin
    state = state_q;
    match = state_q[PAT_LEN];
  end

`ifdef ONEHOT_SEQ_DETECTOR_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating count of edges that land in S_N; clear has priority.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (!pat_load && in_valid && state_nxt_c[PAT_LEN] && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign match_cnt = cnt_q;
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_onehot_seq_detector.sv
// Bench for onehot_seq_detector: two instances (1011/CNT_W=2 and 101/CNT_W=8)
// checked every cycle against a stream-suffix reference model plus literal cases.
module tb_onehot_seq_detector;

  localparam int unsigned N0  = 4;
  localparam int unsigned N1  = 3;
  localparam int unsigned CW0 = 2;
  localparam int unsigned CW1 = 8;

  logic clk = 1'b0;
  logic aresetn = 1'b1;
  logic in_valid = 1'b0;
  logic in = 1'b0;
  logic pat_load = 1'b0;
  logic overlap = 1'b1;
  logic cnt_clr = 1'b0;
  logic [N0-1:0] pat_in0 = '0;
  logic [N1-1:0] pat_in1 = '0;

  logic [N0:0]    state0;
  logic           match0;
  logic [CW0-1:0] cnt0;
  logic [N1:0]    state1;
  logic           match1;
  logic [CW1-1:0] cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  onehot_seq_detector #(.PAT_LEN(N0), .PAT_RST(4'b1011), .CNT_W(CW0)) u_dut0 (
    .clk(clk), .aresetn(aresetn), .in_valid(in_valid), .in(in),
    .pat_load(pat_load), .pat_in(pat_in0), .overlap(overlap), .cnt_clr(cnt_clr),
    .state(state0), .match(match0), .match_cnt(cnt0)
  );

  onehot_seq_detector #(.PAT_LEN(N1), .PAT_RST(3'b101), .CNT_W(CW1)) u_dut1 (
    .clk(clk), .aresetn(aresetn), .in_valid(in_valid), .in(in),
    .pat_load(pat_load), .pat_in(pat_in1), .overlap(overlap), .cnt_clr(cnt_clr),
    .state(state1), .match(match1), .match_cnt(cnt1)
  );

  // Reference model: bits accepted since the last restart, newest at [0].
  int          m_n[2]    = '{4, 3};
  int          m_max[2]  = '{3, 255};
  logic [15:0] m_rst[2]  = '{16'hB, 16'h5};
  logic [15:0] m_pat[2];
  logic [15:0] m_bits[2];
  int          m_len[2];
  int          m_state[2];
  int          m_cnt[2];

  function automatic int longest(input int n, input logic [15:0] pat,
                                 input logic [15:0] bits, input int len);
    int best = 0;
    for (int k = 1; k <= n && k <= len; k++) begin
      if ((32'(bits) & ((32'd1 << k) - 32'd1)) == (32'(pat) >> (n - k))) best = k;
    end
    return best;
  endfunction

  task automatic model_step(input int i, input logic [15:0] p);
    if (pat_load) begin
      m_pat[i]   = p;
      m_len[i]   = 0;
      m_state[i] = 0;
    end else if (in_valid) begin
      if (m_state[i] == m_n[i] && !overlap) m_len[i] = 0;
      m_bits[i] = {m_bits[i][14:0], in};
      if (m_len[i] < 16) m_len[i]++;
      m_state[i] = longest(m_n[i], m_pat[i], m_bits[i], m_len[i]);
      if (m_state[i] == m_n[i] && m_cnt[i] < m_max[i]) m_cnt[i]++;
    end
    if (cnt_clr) m_cnt[i] = 0;
  endtask

  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < 2; i++) begin
        m_pat[i]   = m_rst[i];
        m_bits[i]  = '0;
        m_len[i]   = 0;
        m_state[i] = 0;
        m_cnt[i]   = 0;
      end
    end else begin
      model_step(0, 16'(pat_in0));
      model_step(1, 16'(pat_in1));
    end
  end

  function automatic int ecnt(input int v);
`ifdef ONEHOT_SEQ_DETECTOR_CNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    chk("m_state0", 32'(state0), 32'd1 << m_state[0]);
    chk("m_match0", 32'(match0), 32'(m_state[0] == m_n[0]));
    chk("m_cnt0",   32'(cnt0),   32'(ecnt(m_cnt[0])));
    chk("m_state1", 32'(state1), 32'd1 << m_state[1]);
    chk("m_match1", 32'(match1), 32'(m_state[1] == m_n[1]));
    chk("m_cnt1",   32'(cnt1),   32'(ecnt(m_cnt[1])));
  end

  task automatic step(input logic v, input logic b);
    in_valid = v;
    in       = b;
    @(posedge clk);
    #1;
  endtask

  // Reset pulse strictly between edges, checked while still asserted.
  task automatic pulse_reset();
    in_valid = 1'b0;
    #1 aresetn = 1'b0;
    #1;
    chk("rst_state0", 32'(state0), 32'd1);
    chk("rst_match0", 32'(match0), 32'd0);
    chk("rst_cnt0",   32'(cnt0),   32'd0);
    chk("rst_state1", 32'(state1), 32'd1);
    chk("rst_match1", 32'(match1), 32'd0);
    #1 aresetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  int s0_lit[6] = '{2, 4, 8, 4, 8, 16};
  int s1_lit[6] = '{2, 4, 8, 4, 8, 2};
  int m1_ovl[5] = '{0, 0, 1, 0, 1};
  int m1_non[5] = '{0, 0, 1, 0, 0};
  logic b6[6]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    #1 aresetn = 1'b0;
    #2;
    chk("init_state0", 32'(state0), 32'd1);
    chk("init_state1", 32'(state1), 32'd1);
    chk("init_match0", 32'(match0), 32'd0);
    @(posedge clk);
    #7 aresetn = 1'b1;
    @(posedge clk);
    #1;

    // Overlapping: 1011 walk and 101 matching after bits 3 and 5.
    overlap = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, b6[i]);
      chk("lit_s0_ovl", 32'(state0), 32'(s0_lit[i]));
      chk("lit_s1_ovl", 32'(state1), 32'(s1_lit[i]));
      if (i < 5) chk("lit_m1_ovl", 32'(match1), 32'(m1_ovl[i]));
      if (i == 4) chk("lit_cnt1_ovl", 32'(cnt1), 32'(ecnt(2)));
    end
    chk("lit_cnt0_ovl", 32'(cnt0), 32'(ecnt(1)));

    // Load other patterns, get mid-pattern, then reset between edges.
    pat_load = 1'b1; pat_in0 = 4'b0110; pat_in1 = 3'b011;
    step(1'b0, 1'b0);
    pat_load = 1'b0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("lit_mid_s0", 32'(state0), 32'd4);
    pulse_reset();

    // Non-overlapping after reset; PAT_RST must be back in force.
    overlap = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, b6[i]);
      if (i < 5) chk("lit_m1_non", 32'(match1), 32'(m1_non[i]));
    end
    chk("lit_cnt1_non", 32'(cnt1), 32'(ecnt(1)));
    chk("lit_s0_rst_pat", 32'(state0), 32'd16);

    // Load while in S_2 with in_valid high: bit discarded, new pattern 1100.
    overlap = 1'b1;
    pulse_reset();
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    chk("lit_s2", 32'(state0), 32'd4);
    pat_load = 1'b1; pat_in0 = 4'b1100; pat_in1 = 3'b110;
    step(1'b1, 1'b1);
    pat_load = 1'b0;
    chk("lit_load_s0", 32'(state0), 32'd1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("lit_discard", 32'(state0), 32'd1);
    for (int r = 0; r < 5; r++) begin
      step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b0);
      chk("lit_match_1100", 32'(state0), 32'd16);
    end
    chk("lit_sat", 32'(cnt0), 32'(ecnt(3)));

    // Clear wins over a simultaneous match.
    step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b0);
    cnt_clr = 1'b1;
    step(1'b1, 1'b0);
    cnt_clr = 1'b0;
    chk("lit_clr_state", 32'(state0), 32'd16);
    chk("lit_clr_cnt",   32'(cnt0),   32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      pat_load = ($urandom_range(0, 63) == 0);
      pat_in0  = 4'($urandom);
      pat_in1  = 3'($urandom);
      cnt_clr  = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 15) == 0) overlap = ~overlap;
      step($urandom_range(0, 3) != 0, 1'($urandom));
    end
    pat_load = 1'b0;
    cnt_clr  = 1'b0;
    step(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/onehot_seq_detector.md
ONEHOT_SEQ_DETECTOR -- requirements
Module: onehot_seq_detector

Interface
REQ-001 SHALL have parameter PAT_LEN, default 4, pattern length N in bits, legal range 2..16.
REQ-002 SHALL have parameter PAT_RST, default 4'b1011, pattern value loaded at reset, width PAT_LEN.
REQ-003 SHALL have parameter CNT_W, default 8, match counter width, legal range 1..16.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port aresetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  qualifies in; no state change when low.
REQ-007 SHALL have port in  input  1  serial data bit.
REQ-008 SHALL have port pat_load  input  1  load pat_in into the pattern register.
REQ-009 SHALL have port pat_in  input  PAT_LEN  new pattern; bit PAT_LEN-1 is the first bit expected.
REQ-010 SHALL have port overlap  input  1  1 = overlapping matches, 0 = non-overlapping.
REQ-011 SHALL have port cnt_clr  input  1  synchronous clear of match_cnt.
REQ-012 SHALL have port state  output  PAT_LEN+1  one-hot state register; bit k = S_k = k prefix bits matched.
REQ-013 SHALL have port match  output  1  equals state[PAT_LEN] (Moore, registered).
REQ-014 SHALL have port match_cnt  output  CNT_W  number of matches since reset/clear.

Function
REQ-015 SHALL hold exactly one bit of state set at all times.
REQ-016 SHALL, with in_valid high and pat_load low, move from S_c to S_k where k is the largest value <= c+1 such that the last k accepted bits (current bit last) equal the first k pattern bits; k=0 if none.
REQ-017 SHALL, in S_N with overlap=1, evaluate REQ-016 with c=N over the continuing stream (pattern 101: S_3 on 1 -> S_1, on 0 -> S_2).
REQ-018 SHALL, in S_N with overlap=0, treat the stream as restarted: next state is S_1 if in equals the first pattern bit, else S_0.
REQ-019 SHALL hold state, history and counter when in_valid is low.
REQ-020 SHALL keep a PAT_LEN-bit history shift register of accepted bits for the suffix/prefix compare.
REQ-021 SHALL, on pat_load, capture pat_in, force state to S_0 and clear history on the same edge; the concurrent in bit is discarded (load wins over in_valid).
REQ-022 SHALL assert match for exactly the cycles state is S_N; latency is one clock from the accepting edge.
REQ-023 SHALL increment match_cnt on each edge entering S_N, saturating at all-ones (no wrap).
REQ-024 SHALL give cnt_clr priority over increment on the same edge; result is 0.
REQ-025 SHALL change overlap only between bits; its value on the accepting edge governs that transition.

Reset
REQ-026 SHALL on aresetn low immediately set state=S_0 (state=1), match=0, match_cnt=0, history=0, pattern=PAT_RST.
REQ-027 SHALL resume detection on the first in_valid edge after aresetn deasserts; reset mid-pattern discards the partial match.

Configuration
REQ-028 SHALL compile the match counter only when macro ONEHOT_SEQ_DETECTOR_CNT_EN is defined.
REQ-029 SHALL, without ONEHOT_SEQ_DETECTOR_CNT_EN, keep port match_cnt and drive it constant 0; cnt_clr is ignored; all other behaviour unchanged.

Structure
REQ-030 SHALL place PAT_LEN_MAX=16, CNT_W_MAX=16 and the default pattern constant in shared package seqdet_pkg.
REQ-031 SHALL implement the next-state prefix/suffix compare in one combinational sub-module seqdet_prefix_match (inputs history, in, pattern, current state; output next one-hot state).

Verification
REQ-032 SHALL cover: PAT_LEN=3, pattern 101, overlap=1, stream 1,0,1,0,1 -> match high after bits 3 and 5, match_cnt=2.
REQ-033 SHALL cover: same stream with overlap=0 -> match high after bit 3 only, match_cnt=1.
REQ-034 SHALL cover: pattern 1011, stream 1,0,1,0,1,1 -> states S1,S2,S3,S2,S3,S4, one match.
REQ-035 SHALL cover: pat_load with in_valid high while in S_2 -> state=S_0 next edge, new pattern used, bit discarded.
REQ-036 SHALL cover: CNT_W=2, five matches -> match_cnt saturates at 3; cnt_clr with simultaneous match -> 0.
REQ-037 SHALL cover: aresetn pulsed low mid-pattern between edges -> state=1, match=0 immediately, pattern=PAT_RST.
